// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction memory, and streams one word per
// cycle to decode with a one-entry hold buffer that absorbs decode stalls.
module instruction_fetch #(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_stall,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic [31:0]           i_imem_data,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic [31:0]           o_instr
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(32'd4);
    localparam logic [ADDR_WIDTH-1:0] PC_ZERO  = ADDR_WIDTH'(32'd0);
    localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(RESET_PC);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  resp_pend_q, resp_pend_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]           hold_instr_q, hold_instr_d;

    logic [ADDR_WIDTH-1:0] redirect_addr_s;
    logic [ADDR_WIDTH-1:0] src_pc_s;
    logic [31:0]           src_instr_s;
    logic                  valid_s;
    logic                  stall_s;

    // Output selection: the hold buffer wins over the live memory response.
    always_comb begin
        redirect_addr_s = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        valid_s         = (hold_valid_q | resp_pend_q) & ~i_redirect & ~rst;
        stall_s         = valid_s & i_stall;
        if (rst) begin
            o_imem_addr = fetch_pc_q;
        end else if (i_redirect) begin
            o_imem_addr = redirect_addr_s;
        end else begin
            o_imem_addr = fetch_pc_q;
        end
        if (hold_valid_q) begin
            src_pc_s    = hold_pc_q;
            src_instr_s = hold_instr_q;
        end else begin
            src_pc_s    = resp_pc_q;
            src_instr_s = i_imem_data;
        end
        o_valid = valid_s;
        if (valid_s) begin
            o_pc       = src_pc_s;
            o_pc_plus4 = src_pc_s + PC_STEP;
            o_instr    = src_instr_s;
        end else begin
            o_pc       = PC_ZERO;
            o_pc_plus4 = PC_STEP;
            o_instr    = NOP_INSTR;
        end
    end

    // Next-state: redirect flushes everything, a stall parks the current word
    // in hold (once), otherwise the next address is issued.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        resp_pend_d  = resp_pend_q;
        resp_pc_d    = resp_pc_q;
        hold_valid_d = hold_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        if (i_redirect) begin
            resp_pend_d  = 1'b1;
            resp_pc_d    = redirect_addr_s;
            fetch_pc_d   = redirect_addr_s + PC_STEP;
            hold_valid_d = 1'b0;
        end else if (stall_s) begin
            resp_pend_d = 1'b0;
            if (!hold_valid_q) begin
                hold_valid_d = 1'b1;
                hold_pc_d    = resp_pc_q;
                hold_instr_d = i_imem_data;
            end else begin
                hold_valid_d = 1'b1;
            end
        end else begin
            resp_pend_d  = 1'b1;
            resp_pc_d    = fetch_pc_q;
            fetch_pc_d   = fetch_pc_q + PC_STEP;
            hold_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= PC_RESET;
            resp_pend_q  <= 1'b0;
            resp_pc_q    <= PC_ZERO;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= PC_ZERO;
            hold_instr_q <= 32'd0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_pend_q  <= resp_pend_d;
            resp_pc_q    <= resp_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

endmodule
